// File: rtl/video_frame_wr_sched.sv
// video_frame_wr_sched: frames VS/HS/DE video, packs 4 pixels per 128-bit FIFO word,
// issues one burst request per line and rotates frames through NUM_BUF buffers.
module video_frame_wr_sched #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int NUM_BUF = 3,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BUF_BASE = '0,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = ADDR_W'(32'h0080_0000)
) (
  input  logic              video_clk,
  input  logic              video_rst_n,
  input  logic              enable,
  input  logic              video_vs,
  input  logic              video_hs,
  input  logic              video_de,
  input  logic [23:0]       video_data,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [127:0]      fifo_wr_data,
  output logic              line_req,
  output logic [ADDR_W-1:0] line_addr,
  output logic [9:0]        line_words,
  output logic              frame_done,
  output logic [1:0]        wr_buf_idx,
  output logic [1:0]        rd_buf_idx,
  output logic              overflow_err,
  input  logic              clr_err
);
  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);
  typedef enum logic [2:0] {IDLE, WAIT_DE, ACTIVE, LINE_END, FRAME_END} state_t;
  state_t state_q, state_d;
  logic vs_d1_q, vs_d1_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [LW-1:0] line_q, line_d;
  logic [127:0] pack_q, pack_d, word_q, word_d;
  logic wr_pend_q, wr_pend_d;
  logic started_q, started_d;
  logic bad_q, bad_d;
  logic ovf_q, ovf_d;
  logic [1:0] wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
  logic vs_rise, start, acc, de_fall, last_line, drop;
  logic [1:0] slot;
  logic [31:0] px;
  logic unused_hs;
  assign unused_hs = video_hs;
  assign vs_rise = video_vs & ~vs_d1_q;
  assign start = vs_rise & enable;
  assign acc = video_de & (state_q == WAIT_DE || state_q == ACTIVE) & ~vs_rise & (pix_q < PW'(H_ACTIVE));
  assign de_fall = (state_q == ACTIVE) & ~video_de & ~vs_rise;
  assign last_line = line_q == LW'(V_ACTIVE - 1);
  assign slot = pix_q[1:0];
  assign px = {8'hFF, video_data};
  assign drop = wr_pend_q & fifo_full;
  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (vs_rise) state_d = enable ? WAIT_DE : IDLE;
    else if (state_q == WAIT_DE && video_de) state_d = ACTIVE;
    else if (de_fall) state_d = LINE_END;
    else if (state_q == LINE_END) state_d = last_line ? FRAME_END : WAIT_DE;
    else if (state_q == FRAME_END) state_d = IDLE;
  end
  always_comb begin
    line_req = (state_q == LINE_END) & ~vs_rise;
    frame_done = (state_q == FRAME_END) & ~vs_rise;
    fifo_wr_en = wr_pend_q & ~fifo_full;
    line_addr = line_req ? BUF_BASE + ADDR_W'(wr_buf_q) * BUF_STRIDE + ADDR_W'(line_q) * ADDR_W'(H_ACTIVE * 4) : '0;
    line_words = line_req ? 10'(({1'b0, pix_q} + (PW + 1)'(3)) >> 2) : '0;
  end
  always_comb begin
    vs_d1_d = video_vs;
    pix_d = (state_q == LINE_END || vs_rise) ? '0 : pix_q + PW'(acc);
    pack_d = pack_q;
    word_d = word_q;
    wr_pend_d = 1'b0;
    if (vs_rise) pack_d = '0;
    else if (acc && slot == 2'd3) begin
      word_d = {pack_q[127:32], px};
      pack_d = '0;
      wr_pend_d = 1'b1;
    end else if (acc) pack_d[{~slot, 5'd0} +: 32] = px;
    else if (de_fall) begin
      word_d = pack_q;
      pack_d = '0;
      wr_pend_d = slot != 2'd0;
    end
    line_d = vs_rise ? '0 : line_q + LW'(line_req);
    started_d = started_q | start;
    wr_buf_d = (start && started_q) ? (wr_buf_q == 2'(NUM_BUF - 1) ? 2'd0 : wr_buf_q + 2'd1) : wr_buf_q;
    bad_d = start ? 1'b0 : bad_q | drop;
    rd_buf_d = (frame_done && !bad_q) ? wr_buf_q : rd_buf_q;
    ovf_d = clr_err ? 1'b0 : ovf_q | drop;
  end
  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      vs_d1_q <= 1'b0;
      pix_q <= '0;
      line_q <= '0;
      pack_q <= '0;
      word_q <= '0;
      wr_pend_q <= 1'b0;
      started_q <= 1'b0;
      bad_q <= 1'b0;
      ovf_q <= 1'b0;
      wr_buf_q <= 2'd0;
      rd_buf_q <= 2'(NUM_BUF - 1);
    end else begin
      vs_d1_q <= vs_d1_d;
      pix_q <= pix_d;
      line_q <= line_d;
      pack_q <= pack_d;
      word_q <= word_d;
      wr_pend_q <= wr_pend_d;
      started_q <= started_d;
      bad_q <= bad_d;
      ovf_q <= ovf_d;
      wr_buf_q <= wr_buf_d;
      rd_buf_q <= rd_buf_d;
    end
  end
  assign fifo_wr_data = word_q;
  assign wr_buf_idx = wr_buf_q;
  assign rd_buf_idx = rd_buf_q;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_video_frame_wr_sched.sv
// tb_video_frame_wr_sched: directed frame scenarios on a 4-line x 8-pixel configuration.
module tb_video_frame_wr_sched;
  logic clk, rst_n, enable, vs, hs, de, full, clr_err;
  logic [23:0] data;
  logic wr_en, line_req, frame_done, ovf;
  logic [127:0] wr_data;
  logic [31:0] line_addr;
  logic [9:0] line_words;
  logic [1:0] wr_buf, rd_buf;
  int tests = 0, fails = 0;
  int nw = 0, nl = 0, nfd = 0;
  logic [127:0] wd[512];
  logic [31:0] la[256];
  logic [9:0] lw[256];
  video_frame_wr_sched #(.H_ACTIVE(8), .V_ACTIVE(4), .NUM_BUF(3)) dut (
    .video_clk(clk), .video_rst_n(rst_n), .enable(enable), .video_vs(vs), .video_hs(hs),
    .video_de(de), .video_data(data), .fifo_full(full), .fifo_wr_en(wr_en),
    .fifo_wr_data(wr_data), .line_req(line_req), .line_addr(line_addr),
    .line_words(line_words), .frame_done(frame_done), .wr_buf_idx(wr_buf),
    .rd_buf_idx(rd_buf), .overflow_err(ovf), .clr_err(clr_err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_en) begin wd[nw] = wr_data; nw = nw + 1; end
    if (line_req) begin la[nl] = line_addr; lw[nl] = line_words; nl = nl + 1; end
    if (frame_done) nfd = nfd + 1;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_vs();
    vs = 1; tick(); tick(); vs = 0; tick(); tick();
  endtask
  task automatic send_line(input int n, input logic [23:0] b, input logic f);
    for (int i = 0; i < n; i++) begin
      de = 1; data = b + 24'(i); full = f && i >= 5; tick();
    end
    de = 0; data = 0;
    tick(); tick(); full = 0; tick(); tick();
  endtask
  task automatic test_reset();
    rst_n = 0; enable = 1; vs = 0; hs = 0; de = 0; data = 0; full = 0; clr_err = 0;
    tick(); tick();
    @(negedge clk);
    tests++; if (wr_en !== 0 || line_req !== 0 || frame_done !== 0) begin fails++; $display("FAIL reset_pulses got %b%b%b exp 000", wr_en, line_req, frame_done); end
    tests++; if (wr_data !== 0 || line_addr !== 0 || line_words !== 0) begin fails++; $display("FAIL reset_data got %h/%h/%h exp 0", wr_data, line_addr, line_words); end
    tests++; if (wr_buf !== 0 || rd_buf !== 2) begin fails++; $display("FAIL reset_bufs got %0d/%0d exp 0/2", wr_buf, rd_buf); end
    tests++; if (ovf !== 0) begin fails++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    @(posedge clk); #1 rst_n = 1; tick();
  endtask
  task automatic test_basic();
    int w0 = nw, l0 = nl, f0 = nfd;
    send_vs();
    tests++; if (wr_buf !== 0) begin fails++; $display("FAIL basic_wrbuf got %0d exp 0", wr_buf); end
    for (int l = 0; l < 4; l++) send_line(8, 24'(l * 16 + 1), 0);
    tests++; if (nw - w0 !== 8) begin fails++; $display("FAIL basic_writes got %0d exp 8", nw - w0); end
    tests++; if (nl - l0 !== 4) begin fails++; $display("FAIL basic_reqs got %0d exp 4", nl - l0); end
    for (int l = 0; l < 4; l++) begin
      tests++; if (la[l0 + l] !== 32'(l * 32) || lw[l0 + l] !== 10'd2) begin fails++; $display("FAIL basic_line%0d got %h/%0d exp %h/2", l, la[l0 + l], lw[l0 + l], l * 32); end
    end
    tests++; if (wd[w0] !== {32'hFF000001, 32'hFF000002, 32'hFF000003, 32'hFF000004}) begin fails++; $display("FAIL basic_word0 got %h", wd[w0]); end
    tests++; if (nfd - f0 !== 1 || rd_buf !== 0) begin fails++; $display("FAIL basic_done got %0d/%0d exp 1/0", nfd - f0, rd_buf); end
  endtask
  task automatic test_flush();
    int w0 = nw, l0 = nl, f0 = nfd;
    send_vs();
    send_line(6, 24'h000001, 0);
    for (int l = 1; l < 4; l++) send_line(8, 24'(l * 16 + 1), 0);
    tests++; if (wd[w0 + 1] !== {32'hFF000005, 32'hFF000006, 64'h0}) begin fails++; $display("FAIL flush_word got %h exp ff000005ff0000060000000000000000", wd[w0 + 1]); end
    tests++; if (lw[l0] !== 10'd2 || la[l0] !== 32'h0080_0000) begin fails++; $display("FAIL flush_req got %0d/%h exp 2/00800000", lw[l0], la[l0]); end
    tests++; if (nw - w0 !== 8 || nfd - f0 !== 1 || rd_buf !== 1) begin fails++; $display("FAIL flush_frame got %0d/%0d/%0d exp 8/1/1", nw - w0, nfd - f0, rd_buf); end
  endtask
  task automatic test_overflow();
    int w0 = nw, f0 = nfd;
    send_vs();
    for (int l = 0; l < 4; l++) send_line(8, 24'(l * 16 + 1), l == 1);
    tests++; if (nw - w0 !== 7) begin fails++; $display("FAIL ovf_writes got %0d exp 7", nw - w0); end
    tests++; if (ovf !== 1) begin fails++; $display("FAIL ovf_flag got %b exp 1", ovf); end
    tests++; if (nfd - f0 !== 1 || rd_buf !== 1 || wr_buf !== 2) begin fails++; $display("FAIL ovf_bufs got %0d/%0d/%0d exp 1/1/2", nfd - f0, rd_buf, wr_buf); end
    clr_err = 1; tick(); clr_err = 0;
    tests++; if (ovf !== 0) begin fails++; $display("FAIL ovf_clear got %b exp 0", ovf); end
  endtask
  task automatic test_rotation();
    for (int f = 0; f < 3; f++) begin
      send_vs();
      tests++; if (wr_buf !== 2'(f)) begin fails++; $display("FAIL rot_wrbuf%0d got %0d exp %0d", f, wr_buf, f); end
      for (int l = 0; l < 4; l++) send_line(8, 24'(l * 16 + 1), 0);
      tests++; if (rd_buf !== 2'(f)) begin fails++; $display("FAIL rot_rdbuf%0d got %0d exp %0d", f, rd_buf, f); end
    end
  endtask
  task automatic test_short_frame();
    int f0 = nfd, l0;
    send_vs();
    for (int l = 0; l < 2; l++) send_line(8, 24'(l * 16 + 1), 0);
    send_vs();
    tests++; if (nfd - f0 !== 0 || rd_buf !== 2) begin fails++; $display("FAIL short_abort got %0d/%0d exp 0/2", nfd - f0, rd_buf); end
    tests++; if (wr_buf !== 1) begin fails++; $display("FAIL short_wrbuf got %0d exp 1", wr_buf); end
    l0 = nl;
    for (int l = 0; l < 4; l++) send_line(8, 24'(l * 16 + 1), 0);
    tests++; if (la[l0] !== 32'h0080_0000 || la[l0 + 3] !== 32'h0080_0060) begin fails++; $display("FAIL short_addr got %h/%h exp 00800000/00800060", la[l0], la[l0 + 3]); end
    tests++; if (nfd - f0 !== 1 || rd_buf !== 1) begin fails++; $display("FAIL short_next got %0d/%0d exp 1/1", nfd - f0, rd_buf); end
  endtask
  task automatic test_long_line();
    int w0 = nw, l0 = nl, hit = 0;
    send_vs();
    send_line(12, 24'h000101, 0);
    for (int l = 1; l < 4; l++) send_line(8, 24'(l * 16 + 1), 0);
    tests++; if (nw - w0 !== 8 || lw[l0] !== 10'd2) begin fails++; $display("FAIL long_words got %0d/%0d exp 8/2", nw - w0, lw[l0]); end
    tests++; if (wd[w0 + 1] !== {32'hFF000105, 32'hFF000106, 32'hFF000107, 32'hFF000108}) begin fails++; $display("FAIL long_word1 got %h", wd[w0 + 1]); end
    for (int i = w0; i < nw; i++)
      for (int k = 0; k < 4; k++)
        if (wd[i][k * 32 +: 24] >= 24'h000109 && wd[i][k * 32 +: 24] <= 24'h00010C) hit++;
    tests++; if (hit !== 0) begin fails++; $display("FAIL long_leak got %0d exp 0", hit); end
  endtask
  task automatic test_async_reset();
    send_vs();
    de = 1; data = 24'h0000AA; tick(); tick(); tick();
    #2 rst_n = 0; #1;
    tests++; if (wr_buf !== 0 || rd_buf !== 2 || wr_en !== 0 || wr_data !== 0) begin fails++; $display("FAIL async_rst got %0d/%0d/%b/%h exp 0/2/0/0", wr_buf, rd_buf, wr_en, wr_data); end
    de = 0; tick(); rst_n = 1; tick();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_overflow();
    test_rotation();
    test_short_frame();
    test_long_line();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
